anim_sequencer: RTL and testbench
=================================

ANIM_SEQUENCER -- requirements
Module: anim_sequencer

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 24'd10_000_000, tick period in clocks minus one when period_sel==0.
REQ-002 SHALL have parameter REPEATS, default 2, full passes of an animation before auto-advance; legal range 1..15.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port period_sel  input  8  0 = use MAX_COUNT, else compare = {6'b0, period_sel, 10'b0}.
REQ-006 SHALL have port auto_en  input  1  1 = advance animation after REPEATS passes; 0 = loop current animation.
REQ-007 SHALL have port next_req  input  1  single-cycle pulse requesting advance to next animation.
REQ-008 SHALL have port pause  input  1  level; 1 freezes prescaler, frame and animation.
REQ-009 SHALL have port anim_id  output  3  active animation 0..5 (0 = digit count, 1..5 = effects).
REQ-010 SHALL have port frame  output  4  frame index into active decoder.
REQ-011 SHALL have port frame_stb  output  1  one-cycle pulse on every frame or anim_id change.
REQ-012 SHALL have port blank  output  1  1 = decoder output must be forced dark.
REQ-013 SHALL have port tick_cnt  output  24  prescaler value, debug/uio export.

Function
REQ-014 SHALL implement FSM states ST_PLAY, ST_PAUSE, ST_GAP; reset state ST_PLAY.
REQ-015 SHALL compute compare combinationally each cycle; tick asserted when tick_cnt >= compare, then tick_cnt <= 0, else tick_cnt increments; tick period = compare+1 clocks.
REQ-016 SHALL, on tick in ST_PLAY, set frame <= frame+1, or frame <= 0 when frame == FRAME_MAX[anim_id].
REQ-017 SHALL use FRAME_MAX = {9,6,6,6,5,5} for anim_id 0..5.
REQ-018 SHALL count completed passes in 4-bit loop_cnt; on wrap with auto_en=1 and loop_cnt==REPEATS-1, advance animation and clear loop_cnt, else loop_cnt+1.
REQ-019 SHALL advance animation as anim_id <= (anim_id==5) ? 0 : anim_id+1, with frame, loop_cnt, tick_cnt cleared in the same cycle.
REQ-020 SHALL, on next_req in ST_PLAY, advance animation next cycle regardless of auto_en; next_req wins over a simultaneous tick.
REQ-021 SHALL enter ST_PAUSE when pause=1 (from ST_PLAY or ST_GAP), holding all registers; next_req ignored while paused; return to prior state when pause=0.
REQ-022 SHALL assert frame_stb the cycle after frame or anim_id registers change, low otherwise.
REQ-023 SHALL handle period_sel shrinking below tick_cnt by ticking on the next cycle (>= compare), never wrapping 24 bits.
REQ-024 SHALL clear loop_cnt when auto_en falls, so re-enabling starts a fresh REPEATS count.

Reset
REQ-025 SHALL reset anim_id=0, frame=0, loop_cnt=0, tick_cnt=0, frame_stb=0, blank=0, state ST_PLAY.
REQ-026 SHALL let reset override pause, next_req and any in-progress gap in the same cycle.

Configuration
REQ-027 SHALL honour macro ANIM_BLANK_GAP_EN: when defined, every animation advance first enters ST_GAP with blank=1 for one full tick period, then advances anim_id and returns to ST_PLAY; next_req during ST_GAP ignored.
REQ-028 SHALL, without ANIM_BLANK_GAP_EN, advance directly, omit ST_GAP, and tie blank to 0.

Structure
REQ-029 SHALL place state encodings, ANIM_COUNT=6 and the FRAME_MAX table in shared package anim_pkg, also used by the decoder mux.
REQ-030 SHALL isolate prescaler (compare select, tick_cnt, tick) in sub-module tick_gen.

Verification (MAX_COUNT=4, REPEATS=2)
REQ-031 SHALL cover: reset, period_sel=0, run 50 clocks -> frame 0..9 stepping every 5 clocks, tick_cnt cycles 0..4.
REQ-032 SHALL cover: auto_en=1 from reset -> anim_id goes 0->1 after 20 ticks (2 passes x 10 frames), 5->0 after full cycle.
REQ-033 SHALL cover: next_req coincident with tick at anim_id=2, frame=3 -> next cycle anim_id=3, frame=0, tick_cnt=0, frame_stb=1 following cycle.
REQ-034 SHALL cover: pause=1 for 30 clocks mid-frame -> tick_cnt, frame, anim_id unchanged; next_req pulse ignored; resumes at held tick_cnt.
REQ-035 SHALL cover: period_sel=1 (compare 1024), tick_cnt=900, then period_sel changed to 0 -> tick next cycle, tick_cnt=0.
REQ-036 SHALL cover: ANIM_BLANK_GAP_EN defined, next_req -> blank=1 for 5 clocks with anim_id unchanged, then anim_id+1, blank=0.

Source files
------------

// File: rtl/anim_pkg.sv
// Purpose: shared sequencer types, animation count and per-animation frame limits.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: anim_state_t (ST_PLAY/ST_PAUSE/ST_GAP), ANIM_COUNT, FRAME_MAX table,
//           frame_max() lookup and next_anim() successor, shared with the decoder mux.
package anim_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_GAP   = 2'd2
  } anim_state_t;

  localparam int ANIM_COUNT = 6;

  // Last frame index of each animation: 0 is the 0..9 digit count, 1..5 are effects.
  localparam logic [3:0] FRAME_MAX [ANIM_COUNT] = '{4'd9, 4'd6, 4'd6, 4'd6, 4'd5, 4'd5};

  function automatic logic [3:0] frame_max(input logic [2:0] id);
    logic [3:0] fm;
    fm = 4'd0;
    if (id < 3'(ANIM_COUNT)) fm = FRAME_MAX[id];
    return fm;
  endfunction

  function automatic logic [2:0] next_anim(input logic [2:0] id);
    return (id == 3'(ANIM_COUNT - 1)) ? 3'd0 : id + 3'd1;
  endfunction

endpackage

// File: rtl/anim_sequencer_tick_gen.sv
// Purpose: frame-rate prescaler; free-running counter that pulses tick every compare+1 clocks.
// Latency: tick is combinational from the registered counter; counter updates one clock later.
// Backpressure: run=0 freezes the counter and suppresses tick; clear restarts the period.
// Ports: clk/reset (sync, active-high), period_sel (0 = MAX_COUNT, else period_sel*1024),
//        run, clear, tick_cnt (counter value), tick.
module tick_gen #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  period_sel,
  input  logic        run,
  input  logic        clear,
  output logic [23:0] tick_cnt,
  output logic        tick
);

  logic [23:0] compare;

  always_comb begin
    compare = (period_sel == 8'd0) ? MAX_COUNT : {6'b0, period_sel, 10'b0};
  end

  // >= rather than == so that shrinking the period below the current count
  // ticks on the next cycle instead of running the counter through a 24-bit wrap.
  assign tick = run && (tick_cnt >= compare);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (run) begin
      if (clear || tick) tick_cnt <= '0;
      else               tick_cnt <= tick_cnt + 24'd1;
    end
  end

endmodule

// File: rtl/anim_sequencer.sv
// Purpose: steps frames of the active animation on each prescaler tick and advances animations.
// Latency: frame/anim_id update on the clock after tick or next_req; frame_stb one clock later.
// Backpressure: pause (level) freezes prescaler, frame and animation; next_req dropped while paused.
// Ports: clk, reset (sync, active-high), period_sel, auto_en, next_req, pause,
//        anim_id, frame, frame_stb, blank, tick_cnt.
// Option: define ANIM_BLANK_GAP_EN to insert one blanked tick period before every advance.
module anim_sequencer
  import anim_pkg::*;
#(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter int          REPEATS   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  period_sel,
  input  logic        auto_en,
  input  logic        next_req,
  input  logic        pause,
  output logic [2:0]  anim_id,
  output logic [3:0]  frame,
  output logic        frame_stb,
  output logic        blank,
  output logic [23:0] tick_cnt
);

  localparam logic [3:0] LAST_PASS = 4'(REPEATS - 1);

  anim_state_t state, resume_st, mode;
  logic [3:0]  loop_cnt;
  logic        tick, clr_tick, wrap, auto_adv, adv_req, chg_pend;

  // While ST_PAUSE is registered, behave as the state we were paused from
  // so the first unpaused cycle acts exactly as if pause never happened.
  assign mode = (state == ST_PAUSE) ? resume_st : state;

  always_comb begin
    wrap     = tick && (frame == frame_max(anim_id));
    auto_adv = wrap && auto_en && (loop_cnt >= LAST_PASS);
    adv_req  = (mode == ST_PLAY) && (next_req || auto_adv);
    // A tick restarts the prescaler by itself; only next_req needs an explicit restart.
    clr_tick = (mode == ST_PLAY) && next_req;
  end

  tick_gen #(.MAX_COUNT(MAX_COUNT)) u_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .period_sel (period_sel),
    .run        (!pause),
    .clear      (clr_tick),
    .tick_cnt   (tick_cnt),
    .tick       (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_PLAY;
      resume_st <= ST_PLAY;
      anim_id   <= 3'd0;
      frame     <= 4'd0;
      loop_cnt  <= 4'd0;
      chg_pend  <= 1'b0;
      frame_stb <= 1'b0;
    end else begin
      // chg_pend marks the edge where frame/anim_id moved; the strobe follows one clock later.
      frame_stb <= chg_pend;
      chg_pend  <= 1'b0;
      if (pause) begin
        if (state != ST_PAUSE) begin
          resume_st <= state;
          state     <= ST_PAUSE;
        end
      end else begin
        state <= mode;
`ifdef ANIM_BLANK_GAP_EN
        if (mode == ST_GAP) begin
          if (tick) begin
            anim_id  <= next_anim(anim_id);
            frame    <= 4'd0;
            loop_cnt <= 4'd0;
            state    <= ST_PLAY;
            chg_pend <= 1'b1;
          end
        end else if (adv_req) begin
          state    <= ST_GAP;
          loop_cnt <= 4'd0;
          // An auto advance still shows its frame wrap; next_req leaves the frame alone.
          if (!next_req) begin
            frame    <= 4'd0;
            chg_pend <= 1'b1;
          end
        end else
`else
        if (adv_req) begin
          anim_id  <= next_anim(anim_id);
          frame    <= 4'd0;
          loop_cnt <= 4'd0;
          chg_pend <= 1'b1;
        end else
`endif
        if (tick) begin
          chg_pend <= 1'b1;
          if (wrap) begin
            frame    <= 4'd0;
            loop_cnt <= loop_cnt + 4'd1;
          end else begin
            frame    <= frame + 4'd1;
          end
        end
        // Holding the pass count at zero while auto is off means re-enabling
        // always starts a fresh REPEATS count.
        if (!auto_en) loop_cnt <= 4'd0;
      end
    end
  end

`ifdef ANIM_BLANK_GAP_EN
  always_ff @(posedge clk) begin
    if (reset)       blank <= 1'b0;
    else if (!pause) blank <= adv_req || (blank && !tick);
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_anim_sequencer.sv
module tb_anim_sequencer;

  localparam logic [23:0] MAXC = 24'd4;
  localparam int          REP  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  period_sel = 8'd0;
  logic        auto_en = 1'b0;
  logic        next_req = 1'b0;
  logic        pause = 1'b0;
  logic [2:0]  anim_id;
  logic [3:0]  frame;
  logic        frame_stb;
  logic        blank;
  logic [23:0] tick_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  anim_sequencer #(.MAX_COUNT(MAXC), .REPEATS(REP)) dut (
    .clk        (clk),
    .reset      (reset),
    .period_sel (period_sel),
    .auto_en    (auto_en),
    .next_req   (next_req),
    .pause      (pause),
    .anim_id    (anim_id),
    .frame      (frame),
    .frame_stb  (frame_stb),
    .blank      (blank),
    .tick_cnt   (tick_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_anim, m_frame, m_pass, m_cnt, m_gap, m_chg, m_stb;
  bit m_valid = 1'b0;
  int fmax [6] = '{9, 6, 6, 6, 5, 5};

  function automatic int period_cmp(input int ps);
    return (ps == 0) ? int'(MAXC) : ps * 1024;
  endfunction

  task automatic begin_advance();
`ifdef ANIM_BLANK_GAP_EN
    m_gap  = 1;
    m_cnt  = 0;
    m_pass = 0;
`else
    m_anim  = (m_anim + 1) % 6;
    m_frame = 0;
    m_pass  = 0;
    m_cnt   = 0;
`endif
  endtask

  task automatic model_step();
    int oa, of;
    bit tk;
    oa = m_anim;
    of = m_frame;
    m_stb = m_chg;
    m_chg = 0;
    if (reset) begin
      m_anim = 0; m_frame = 0; m_pass = 0; m_cnt = 0; m_gap = 0; m_stb = 0;
      m_valid = 1'b1;
    end else if (!pause) begin
      tk = (m_cnt >= period_cmp(int'(period_sel)));
      if (m_gap != 0) begin
        if (tk) begin
          m_gap = 0; m_anim = (m_anim + 1) % 6; m_frame = 0; m_pass = 0; m_cnt = 0;
        end else m_cnt++;
      end else if (next_req) begin
        begin_advance();
      end else if (tk) begin
        m_cnt = 0;
        if (m_frame == fmax[m_anim]) begin
          m_frame = 0;
          if (auto_en && (m_pass + 1 >= REP)) begin_advance();
          else m_pass++;
        end else m_frame++;
      end else m_cnt++;
      if (!auto_en) m_pass = 0;
      m_chg = ((oa != m_anim) || (of != m_frame)) ? 1 : 0;
    end
  endtask

  // Single compare process: model advances on each edge, DUT checked 1ns later.
  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    if (m_valid) begin
      check("anim_id",   int'(anim_id),   m_anim);
      check("frame",     int'(frame),     m_frame);
      check("tick_cnt",  int'(tick_cnt),  m_cnt);
      check("frame_stb", int'(frame_stb), m_stb);
      check("blank",     int'(blank),     m_gap);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; next_req = 1'b0; pause = 1'b0;
    cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    cycles(2);
    check("rst_anim", int'(anim_id), 0);
    check("rst_frame", int'(frame), 0);
    check("rst_tick", int'(tick_cnt), 0);
    check("rst_stb", int'(frame_stb), 0);
    check("rst_blank", int'(blank), 0);

    // default period, looping digit count
    auto_en = 1'b0; period_sel = 8'd0;
    do_reset();
    cycles(5);
    check("p1_frame5", int'(frame), 1);
    check("p1_tick5", int'(tick_cnt), 0);
    check("p1_stb5", int'(frame_stb), 0);
    cycles(1);
    check("p1_stb6", int'(frame_stb), 1);
    cycles(39);
    check("p1_frame45", int'(frame), 9);
    cycles(5);
    check("p1_frame50", int'(frame), 0);
    check("p1_anim50", int'(anim_id), 0);

`ifndef ANIM_BLANK_GAP_EN
    // auto advance through the full animation cycle
    auto_en = 1'b1;
    do_reset();
    cycles(99);
    check("p2_anim99", int'(anim_id), 0);
    check("p2_frame99", int'(frame), 9);
    check("p2_tick99", int'(tick_cnt), 4);
    cycles(1);
    check("p2_anim100", int'(anim_id), 1);
    cycles(270);
    check("p2_anim370", int'(anim_id), 5);
    cycles(59);
    check("p2_anim429", int'(anim_id), 5);
    cycles(1);
    check("p2_anim430", int'(anim_id), 0);

    // next_req coincident with a tick at anim 2 frame 3
    do_reset();
    cycles(189);
    check("p3_pre_anim", int'(anim_id), 2);
    check("p3_pre_frame", int'(frame), 3);
    check("p3_pre_tick", int'(tick_cnt), 4);
    next_req = 1'b1;
    cycles(1);
    next_req = 1'b0;
    check("p3_anim", int'(anim_id), 3);
    check("p3_frame", int'(frame), 0);
    check("p3_tick", int'(tick_cnt), 0);
    check("p3_stb0", int'(frame_stb), 0);
    cycles(1);
    check("p3_stb1", int'(frame_stb), 1);
`else
    // blanked gap before an advance
    auto_en = 1'b0;
    do_reset();
    cycles(2);
    next_req = 1'b1;
    cycles(1);
    next_req = 1'b0;
    check("gap_blank0", int'(blank), 1);
    check("gap_anim0", int'(anim_id), 0);
    check("gap_tick0", int'(tick_cnt), 0);
    cycles(4);
    check("gap_blank4", int'(blank), 1);
    check("gap_anim4", int'(anim_id), 0);
    check("gap_tick4", int'(tick_cnt), 4);
    cycles(1);
    check("gap_blank5", int'(blank), 0);
    check("gap_anim5", int'(anim_id), 1);
`endif

    // pause mid-frame, next_req ignored
    auto_en = 1'b0;
    do_reset();
    cycles(7);
    check("p4_frame7", int'(frame), 1);
    check("p4_tick7", int'(tick_cnt), 2);
    pause = 1'b1;
    cycles(15);
    next_req = 1'b1;
    cycles(1);
    next_req = 1'b0;
    cycles(14);
    check("p4_hold_anim", int'(anim_id), 0);
    check("p4_hold_frame", int'(frame), 1);
    check("p4_hold_tick", int'(tick_cnt), 2);
    pause = 1'b0;
    cycles(2);
    check("p4_res_tick", int'(tick_cnt), 4);
    check("p4_res_frame", int'(frame), 1);
    cycles(1);
    check("p4_res_frame2", int'(frame), 2);
    check("p4_res_tick0", int'(tick_cnt), 0);

    // period shrinks below the running count
    period_sel = 8'd1;
    do_reset();
    cycles(900);
    check("p5_tick900", int'(tick_cnt), 900);
    check("p5_frame900", int'(frame), 0);
    period_sel = 8'd0;
    cycles(1);
    check("p5_tick_after", int'(tick_cnt), 0);
    check("p5_frame_after", int'(frame), 1);

    // randomized traffic against the model
    auto_en = 1'b1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 699) == 0);
      next_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
      if (period_sel != 8'd0) begin
        if ($urandom_range(0, 39) == 0) period_sel = 8'd0;
      end else if ($urandom_range(0, 399) == 0) begin
        period_sel = 8'($urandom_range(1, 255));
      end
    end
    @(negedge clk);
    reset = 1'b0; next_req = 1'b0; pause = 1'b0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
